// File: rtl/align_sched_ctrl_pkg.sv
// Shared types and widths for the alignment run sequencer.
package align_sched_ctrl_pkg;

  localparam int unsigned DEF_LEN_WIDTH  = 8;
  localparam int unsigned DIAG_WIDTH     = DEF_LEN_WIDTH + 1;
  localparam int unsigned SCORE_WIDTH    = 16;
  localparam int unsigned ROW_BITS_WIDTH = 8;
  localparam int unsigned COL_BITS_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE,
    DRAIN,
    CAPTURE,
    RESULT
  } align_state_t;

  // Final maximum as returned on the result port.
  typedef struct packed {
    logic [SCORE_WIDTH-1:0]    score;
    logic [ROW_BITS_WIDTH-1:0] row;
    logic [COL_BITS_WIDTH-1:0] col;
  } max_result_t;

endpackage

// File: rtl/align_sched_ctrl_valid_delay_line.sv
// 1-bit valid shift register; out_valid is in_valid delayed DEPTH cycles.
// any_pending_c flags any valid still travelling through the line.
module valid_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic out_valid,
  output logic any_pending_c
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  // Shift new valid in at bit 0; the oldest bit falls off the top.
  always_comb begin
    shift_d = DEPTH'({shift_q, in_valid});
  end

  // Shift register with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shift_q <= '0;
    else        shift_q <= shift_d;
  end

  assign out_valid     = shift_q[DEPTH-1];
  assign any_pending_c = |shift_q;

endmodule

// File: rtl/align_sched_ctrl.sv
// Sequencer for one local-alignment run: drives the PE wavefront, the
// max-register write enable, and returns the final max over valid/ready.
// Optional: ALIGN_SCHED_PERF_CNT_EN adds cycle_cnt (start accept to result).
module align_sched_ctrl
  import align_sched_ctrl_pkg::*;
#(
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned PE_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      query_len,
  input  logic [LEN_WIDTH-1:0]      ref_len,
  output logic                      busy,
  output logic                      pe_en,
  output logic [LEN_WIDTH:0]        diag_idx,
  output logic                      wr_en_max,
  input  logic [SCORE_WIDTH-1:0]    max_score_in,
  input  logic [ROW_BITS_WIDTH-1:0] max_row_in,
  input  logic [COL_BITS_WIDTH-1:0] max_col_in,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SCORE_WIDTH-1:0]    res_score,
  output logic [ROW_BITS_WIDTH-1:0] res_row,
  output logic [COL_BITS_WIDTH-1:0] res_col
`ifdef ALIGN_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]               cycle_cnt
`endif
);

  localparam int unsigned DIAG_W = LEN_WIDTH + 1;

  align_state_t      state_q,     state_d;
  logic [DIAG_W-1:0] n_diag_q,    n_diag_d;
  logic [DIAG_W-1:0] diag_q,      diag_d;
  logic              zero_res_q,  zero_res_d;
  logic              pe_en_q,     pe_en_d;
  logic              busy_q,      busy_d;
  logic              res_valid_q, res_valid_d;
  max_result_t       res_q,       res_d;
  logic              accept_c;
  logic              any_pending_c;

  // Delays pe_en by the PE pipeline depth to form the max-register enable.
  valid_delay_line #(
    .DEPTH (PE_LATENCY)
  ) u_delay (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (pe_en_q),
    .out_valid     (wr_en_max),
    .any_pending_c (any_pending_c)
  );

  // Next-state and registered-output logic for the run sequence.
  always_comb begin
    state_d     = state_q;
    n_diag_d    = n_diag_q;
    diag_d      = diag_q;
    zero_res_d  = zero_res_q;
    pe_en_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    accept_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          n_diag_d = DIAG_W'(query_len) + DIAG_W'(ref_len) - DIAG_W'(1);
          diag_d   = '0;
          if ((query_len == '0) || (ref_len == '0)) begin
            zero_res_d = 1'b1;
            state_d    = CAPTURE;
          end else begin
            zero_res_d = 1'b0;
            pe_en_d    = 1'b1;
            state_d    = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        // diag_idx holds its last value once the final diagonal is issued.
        if (diag_q == (n_diag_q - DIAG_W'(1))) begin
          state_d = DRAIN;
        end else begin
          pe_en_d = 1'b1;
          diag_d  = diag_q + DIAG_W'(1);
        end
      end
      DRAIN: begin
        // Line empty means the last enable reached the max register last
        // cycle; this cycle lets that update settle before capture.
        if (!any_pending_c) state_d = CAPTURE;
      end
      CAPTURE: begin
        res_d       = zero_res_q ? '0 : max_result_t'{max_score_in, max_row_in, max_col_in};
        res_valid_d = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_diag_q    <= '0;
      diag_q      <= '0;
      zero_res_q  <= 1'b0;
      pe_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      n_diag_q    <= n_diag_d;
      diag_q      <= diag_d;
      zero_res_q  <= zero_res_d;
      pe_en_q     <= pe_en_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign busy      = busy_q;
  assign pe_en     = pe_en_q;
  assign diag_idx  = diag_q;
  assign res_valid = res_valid_q;
  assign res_score = res_q.score;
  assign res_row   = res_q.row;
  assign res_col   = res_q.col;

`ifdef ALIGN_SCHED_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Run-length counter: the accept cycle counts as 1; stops when the result
  // becomes valid and saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_c) begin
      cnt_d = 32'd1;
    end else if (busy_q && !res_valid_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_align_sched_ctrl.sv
// Self-checking bench for align_sched_ctrl: randomized runs checked against
// expected timing derived from run lengths and a stand-in max register.
module tb_align_sched_ctrl;
  import align_sched_ctrl_pkg::*;

  localparam int unsigned LW  = 8;
  localparam int unsigned LAT = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic [LW-1:0]             query_len = '0;
  logic [LW-1:0]             ref_len = '0;
  logic                      busy, pe_en, wr_en_max, res_valid;
  logic [LW:0]               diag_idx;
  logic [SCORE_WIDTH-1:0]    max_score_in, res_score;
  logic [ROW_BITS_WIDTH-1:0] max_row_in, res_row;
  logic [COL_BITS_WIDTH-1:0] max_col_in, res_col;
  logic                      res_ready = 1'b0;
`ifdef ALIGN_SCHED_PERF_CNT_EN
  logic [31:0]               cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  align_sched_ctrl #(.LEN_WIDTH(LW), .PE_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .query_len    (query_len),
    .ref_len      (ref_len),
    .busy         (busy),
    .pe_en        (pe_en),
    .diag_idx     (diag_idx),
    .wr_en_max    (wr_en_max),
    .max_score_in (max_score_in),
    .max_row_in   (max_row_in),
    .max_col_in   (max_col_in),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_score    (res_score),
    .res_row      (res_row),
    .res_col      (res_col)
`ifdef ALIGN_SCHED_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in max register: loads fresh random values on every wr_en_max.
  logic [SCORE_WIDTH-1:0]    m_score, g_score;
  logic [ROW_BITS_WIDTH-1:0] m_row, g_row;
  logic [COL_BITS_WIDTH-1:0] m_col, g_col;
  logic                      scramble = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_score <= '0; m_row <= '0; m_col <= '0;
    end else if (wr_en_max) begin
      m_score <= SCORE_WIDTH'($urandom);
      m_row   <= ROW_BITS_WIDTH'($urandom);
      m_col   <= COL_BITS_WIDTH'($urandom);
    end
  end

  // While a result is held, the max inputs wander to prove res_* is latched.
  assign max_score_in = scramble ? g_score : m_score;
  assign max_row_in   = scramble ? g_row   : m_row;
  assign max_col_in   = scramble ? g_col   : m_col;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One complete run: start, observe every cycle, then compare the observed
  // schedule with the one implied by the lengths.
  task automatic run(input int q, input int r, input int rdy_dly, input string nm);
    int n, k, bound, vcnt, hs_k, v_first;
    int pe_cnt, pe_first, pe_last, wr_cnt, wr_first, wr_last;
    logic done;
    logic [SCORE_WIDTH-1:0]    e_s;
    logic [ROW_BITS_WIDTH-1:0] e_r;
    logic [COL_BITS_WIDTH-1:0] e_c;

    n = (q == 0 || r == 0) ? 0 : q + r - 1;
    bound = 2 * (q + r) + rdy_dly + int'(LAT) + 20;
    pe_cnt = 0; pe_first = -1; pe_last = -1;
    wr_cnt = 0; wr_first = -1; wr_last = -1;
    vcnt = 0; hs_k = -1; v_first = -1; done = 1'b0;
    e_s = '0; e_r = '0; e_c = '0;

    @(negedge clk);
    start = 1'b1; query_len = LW'(q); ref_len = LW'(r);
    res_ready = 1'b0; scramble = 1'b0;
    k = 0;

    while (!done && k < bound) begin
      @(negedge clk);
      k++;
      if (pe_en) begin
        pe_cnt++;
        if (pe_first < 0) pe_first = k;
        pe_last = k;
        check({nm, ":diag"}, 64'(diag_idx), 64'(k - 1));
      end
      if (wr_en_max) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = k;
        wr_last = k;
      end
      if (hs_k >= 0) begin
        check({nm, ":busy_after"}, 64'(busy), 64'(0));
        check({nm, ":valid_after"}, 64'(res_valid), 64'(0));
`ifdef ALIGN_SCHED_PERF_CNT_EN
        check({nm, ":cnt_held"}, 64'(cycle_cnt), 64'(v_first));
`endif
        done = 1'b1;
      end else begin
        check({nm, ":busy"}, 64'(busy), 64'(1));
        if (res_valid) begin
          if (v_first < 0) begin
            v_first = k;
            if (n != 0) begin
              e_s = m_score; e_r = m_row; e_c = m_col;
            end
`ifdef ALIGN_SCHED_PERF_CNT_EN
            check({nm, ":cycle_cnt"}, 64'(cycle_cnt), 64'(k));
`endif
          end
          check({nm, ":res_score"}, 64'(res_score), 64'(e_s));
          check({nm, ":res_row"}, 64'(res_row), 64'(e_r));
          check({nm, ":res_col"}, 64'(res_col), 64'(e_c));
          vcnt++;
          res_ready = (vcnt > rdy_dly);
          if (res_ready) hs_k = k;
          scramble = 1'b1;
          g_score = SCORE_WIDTH'($urandom);
          g_row   = ROW_BITS_WIDTH'($urandom);
          g_col   = COL_BITS_WIDTH'($urandom);
        end else begin
          res_ready = 1'($urandom_range(0, 1));
        end
      end
      if (done) begin
        start = 1'b0; res_ready = 1'b0; scramble = 1'b0;
      end else begin
        // Busy-time start pulses and length changes must have no effect.
        start = 1'($urandom_range(0, 1));
        query_len = LW'($urandom);
        ref_len   = LW'($urandom);
      end
    end

    if (!done) begin
      check({nm, ":timeout"}, 64'(0), 64'(1));
      start = 1'b0; res_ready = 1'b0; scramble = 1'b0;
    end
    check({nm, ":pe_count"}, 64'(pe_cnt), 64'(n));
    check({nm, ":wr_count"}, 64'(wr_cnt), 64'(n));
    if (n > 0) begin
      check({nm, ":pe_first"}, 64'(pe_first), 64'(1));
      check({nm, ":pe_last"}, 64'(pe_last), 64'(n));
      check({nm, ":wr_first"}, 64'(wr_first), 64'(1 + int'(LAT)));
      check({nm, ":wr_last"}, 64'(wr_last), 64'(n + int'(LAT)));
    end
    check({nm, ":valid_at"}, 64'(v_first), 64'((n == 0) ? 2 : n + int'(LAT) + 3));
    check({nm, ":diag_hold"}, 64'(diag_idx), 64'((n == 0) ? 0 : n - 1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pe_en", 64'(pe_en), 64'(0));
    check("rst_wr_en", 64'(wr_en_max), 64'(0));
    check("rst_valid", 64'(res_valid), 64'(0));
    check("rst_diag", 64'(diag_idx), 64'(0));
    check("rst_res", 64'({res_score, res_row, res_col}), 64'(0));
    rst_n = 1'b1;

    run(4, 3, 0, "r4x3");
    run(0, 5, 0, "r0x5");
    run(4, 3, 10, "r4x3_hold");
    run(1, 1, 0, "r1x1");
    run(5, 0, 2, "r5x0");
    run(255, 255, 1, "r255x255");

    // Abort mid-COMPUTE with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; query_len = LW'(10); ref_len = LW'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_pe_en", 64'(pe_en), 64'(0));
    check("abort_wr_en", 64'(wr_en_max), 64'(0));
    check("abort_diag", 64'(diag_idx), 64'(0));
    check("abort_valid", 64'(res_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run(4, 3, 0, "after_abort");

    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
          int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
